// File: rtl/proc_pkg.sv
// Shared constants and the writeback request type for the register-file write path.
package proc_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous load-return FIFO; also exposes every slot's valid bit and address
// so the parent can build its pending-write mask.
module wb_fifo #(
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = 16,
  parameter int  ADDR_W = 5,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_addr_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic [ADDR_W-1:0]            head_addr_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic [CW-1:0]                count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DEPTH-1:0]             ent_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_o
);

  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;

  assign head_addr_o = addr_mem[rd_q];
  assign head_data_o = data_mem[rd_q];

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_q] <= push_addr_i;
      data_mem[wr_q] <= push_data_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off            = PW'(i) - rd_q;
    assign ent_valid_o[i] = ({1'b0, off} < count_q);
    assign ent_addr_o[i]  = addr_mem[i];
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Writeback arbiter: ALU results beat buffered load returns, loads bypass when idle,
// and a defer counter raises aluStall so a waiting load cannot starve.
module reg_writeback_arbiter #(
  parameter int  DATA_W    = proc_pkg::DATA_W,
  parameter int  ADDR_W    = proc_pkg::ADDR_W,
  parameter int  DEPTH     = 4,
  parameter int  MAX_DEFER = 8,
  localparam int CW        = $clog2(DEPTH) + 1,
  localparam int NUM_REGS  = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aluValid,
  input  logic [ADDR_W-1:0]   aluAddr,
  input  logic [DATA_W-1:0]   aluData,
  input  logic                ldValid,
  output logic                ldReady,
  input  logic [ADDR_W-1:0]   ldAddr,
  input  logic [DATA_W-1:0]   ldData,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   writeAddr,
  output logic [DATA_W-1:0]   writeData,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic                aluStall,
  output logic [CW-1:0]       fifoCount
);

  localparam int DFW = $clog2(MAX_DEFER + 1);

  logic                        regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]           waddr_q, waddr_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;
  logic [DFW-1:0]              defer_q, defer_d;
  logic                        stall_q, stall_d;
  logic                        fifo_full, fifo_empty;
  logic                        ld_accept, sel_pop, sel_bypass, push;
  logic [ADDR_W-1:0]           head_addr;
  logic [DATA_W-1:0]           head_data;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;

  // Handshake: a load transfers at a rising edge when ldValid && ldReady; ldReady
  // depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign ldReady    = !reset && !fifo_full;
  assign ld_accept  = ldValid && ldReady;
  assign sel_pop    = !aluValid && !fifo_empty;
  assign sel_bypass = !aluValid && fifo_empty && ld_accept;
  assign push       = ld_accept && !sel_bypass;

  wb_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_addr_i(ldAddr),
    .push_data_i(ldData),
    .pop_i      (sel_pop),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .count_o    (fifoCount),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .ent_valid_o(ent_valid),
    .ent_addr_o (ent_addr)
  );

  always_comb begin
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (aluValid) begin
      regwrite_d = 1'b1;
      waddr_d    = aluAddr;
      wdata_d    = aluData;
    end else if (sel_pop) begin
      regwrite_d = 1'b1;
      waddr_d    = head_addr;
      wdata_d    = head_data;
    end else if (sel_bypass) begin
      regwrite_d = 1'b1;
      waddr_d    = ldAddr;
      wdata_d    = ldData;
    end

    // Counter saturates at MAX_DEFER; the stall flag then holds until the head pops.
    defer_d = defer_q;
    if (fifo_empty || sel_pop)                          defer_d = '0;
    else if (aluValid && defer_q != DFW'(MAX_DEFER))    defer_d = defer_q + 1'b1;

    stall_d = stall_q;
    if (sel_pop)                             stall_d = 1'b0;
    else if (defer_d == DFW'(MAX_DEFER))     stall_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      defer_q    <= '0;
      stall_q    <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      defer_q    <= defer_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pendingMask[ent_addr[i]] = 1'b1;
    end
    if (regwrite_q) pendingMask[waddr_q] = 1'b1;
  end

  assign RegWrite  = regwrite_q;
  assign writeAddr = waddr_q;
  assign writeData = wdata_q;
  assign aluStall  = stall_q;

endmodule
